// File: rtl/led_sequencer.sv
// led_sequencer: 8-LED pattern generator with a prescaled step clock and a
// valid/ready command port for mode, step speed, pause and direct pattern load.
module led_sequencer #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_DIV = CLK_FREQ / 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic [7:0] leds,
    output logic [1:0] mode,
    output logic       paused,
    output logic       step_pulse
);

    localparam int             PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]     SPEED_RST = 8'd49;

    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_APPLY} state_e;
    typedef enum logic [1:0] {OP_SET_MODE, OP_SET_SPEED, OP_PAUSE, OP_LOAD} op_e;
    typedef enum logic [1:0] {M_SHIFT, M_BOUNCE, M_BLINK, M_COUNT} mode_e;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [7:0]       arg_q, arg_d;
    logic [7:0]       leds_q, leds_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       speed_q, speed_d;
    dir_e             dir_q, dir_d;
    logic             pause_q, pause_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [7:0]       stc_q, stc_d;
    logic             step_pulse_q, step_pulse_d;

    logic cmd_accept;
    logic tick;
    logic step;

    assign cmd_ready  = (state_q != ST_APPLY);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign tick       = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    assign step       = tick && (stc_q == speed_q);

    assign leds       = leds_q;
    assign mode       = mode_q;
    assign paused     = pause_q;
    assign step_pulse = step_pulse_q;

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        op_d         = op_q;
        arg_d        = arg_q;
        leds_d       = leds_q;
        mode_d       = mode_q;
        speed_d      = speed_q;
        dir_d        = dir_q;
        pause_d      = pause_q;
        pre_d        = pre_q;
        stc_d        = stc_q;
        step_pulse_d = 1'b0;

        if (state_q == ST_RUN) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                stc_d = step ? 8'd0 : stc_q + 8'd1;
            end
        end

        if (step) begin
            step_pulse_d = 1'b1;
            unique case (mode_q)
                M_SHIFT:  leds_d = {leds_q[6:0], leds_q[7]};
                M_BOUNCE: begin
                    if (dir_q == DIR_LEFT) begin
                        if (leds_q[7]) begin
                            dir_d  = DIR_RIGHT;
                            leds_d = leds_q >> 1;
                        end else begin
                            leds_d = leds_q << 1;
                        end
                    end else begin
                        if (leds_q[0]) begin
                            dir_d  = DIR_LEFT;
                            leds_d = leds_q << 1;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end
                end
                M_BLINK:  leds_d = ~leds_q;
                M_COUNT:  leds_d = leds_q + 8'd1;
            endcase
        end

        // Steps only happen in RUN, so APPLY never competes with the step logic above.
        unique case (state_q)
            ST_RUN, ST_HALT: begin
                if (cmd_accept) begin
                    state_d = ST_APPLY;
                    op_d    = op_e'(cmd_op);
                    arg_d   = cmd_arg;
                end
            end
            ST_APPLY: begin
                unique case (op_q)
                    OP_SET_MODE: begin
                        mode_d = mode_e'(arg_q[1:0]);
                        pre_d  = '0;
                        stc_d  = 8'd0;
                        unique case (mode_e'(arg_q[1:0]))
                            M_SHIFT:  leds_d = 8'h01;
                            M_BOUNCE: begin
                                leds_d = 8'h01;
                                dir_d  = DIR_LEFT;
                            end
                            M_BLINK:  leds_d = 8'h00;
                            M_COUNT:  leds_d = 8'h00;
                        endcase
                    end
                    OP_SET_SPEED: begin
                        speed_d = arg_q;
                        pre_d   = '0;
                        stc_d   = 8'd0;
                    end
                    OP_PAUSE: pause_d = arg_q[0];
                    OP_LOAD: begin
                        leds_d = arg_q;
                        pre_d  = '0;
                        stc_d  = 8'd0;
                    end
                endcase
                state_d = pause_d ? ST_HALT : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            op_q         <= OP_SET_MODE;
            arg_q        <= 8'h00;
            leds_q       <= 8'h01;
            mode_q       <= M_SHIFT;
            speed_q      <= SPEED_RST;
            dir_q        <= DIR_LEFT;
            pause_q      <= 1'b0;
            pre_q        <= '0;
            stc_q        <= 8'd0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arg_q        <= arg_d;
            leds_q       <= leds_d;
            mode_q       <= mode_d;
            speed_q      <= speed_d;
            dir_q        <= dir_d;
            pause_q      <= pause_d;
            pre_q        <= pre_d;
            stc_q        <= stc_d;
            step_pulse_q <= step_pulse_d;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer (TICK_DIV=4): expected step patterns and their edge
// numbers are queued as commands are issued and compared when step_pulse fires.
module tb_led_sequencer;

    localparam int TD = 4;
    localparam logic [1:0] OP_SET_MODE = 2'd0, OP_SET_SPEED = 2'd1, OP_PAUSE = 2'd2, OP_LOAD = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_arg = 8'h00;
    logic       cmd_ready;
    logic [7:0] leds;
    logic [1:0] mode;
    logic       paused;
    logic       step_pulse;

    typedef struct {
        logic [7:0] leds;
        int         cyc;
    } step_t;

    step_t sb_q[$];
    bit    sb_en = 1'b0;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    logic [7:0] exp_shift  [9]  = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
    logic [7:0] exp_bounce [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    logic [7:0] b2b_op  [3] = '{OP_SET_SPEED, OP_SET_MODE, OP_LOAD};
    logic [7:0] b2b_arg [3] = '{8'd3, 8'd3, 8'h10};

    led_sequencer #(.CLK_FREQ(400), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .leds      (leds),
        .mode      (mode),
        .paused    (paused),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] v, input int c);
        step_t e;
        e.leds = v;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    // Each step pulse consumes one expected entry: pattern and the edge it appeared on.
    always @(negedge clk) begin : monitor
        step_t e;
        if (sb_en && step_pulse) begin
            if (sb_q.size() == 0) begin
                check("unexpected_step", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("step_leds", leds, e.leds);
                check("step_edge", cyc, e.cyc);
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Returns the APPLY edge number; ends at the falling edge after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg, output int apply_cyc);
        int waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        while (!cmd_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        apply_cyc = cyc + 2;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ready_low_in_apply", cmd_ready, 0);
    endtask

    initial begin
        int ap;
        int rel;
        int chg;
        int k;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_leds", leds, 8'h01);
        check("rst_mode", mode, 2'd0);
        check("rst_paused", paused, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_step_pulse", step_pulse, 0);

        // First step with default speed 49: edge TD*50 after release
        rst = 1'b0;
        rel = cyc;
        push(8'h02, rel + TD * 50);
        sb_en = 1'b1;
        wait_drain("default_first_step", 260);
        sb_en = 1'b0;

        // SHIFT at speed 1: 8-cycle period, wraps 0x80 -> 0x01
        send_cmd(OP_SET_SPEED, 8'd1, ap);
        for (int i = 0; i < 9; i++) push(exp_shift[i], ap + 8 * (i + 1));
        @(negedge clk);
        check("speed_keeps_leds", leds, 8'h02);
        sb_en = 1'b1;
        wait_drain("shift_drain", 120);
        sb_en = 1'b0;

        // BOUNCE at speed 0: reverses at both ends
        send_cmd(OP_SET_MODE, 8'd1, ap);
        send_cmd(OP_SET_SPEED, 8'd0, ap);
        for (int i = 0; i < 16; i++) push(exp_bounce[i], ap + 4 * (i + 1));
        @(negedge clk);
        check("bounce_init_leds", leds, 8'h01);
        check("bounce_mode", mode, 2'd1);
        sb_en = 1'b1;
        wait_drain("bounce_drain", 100);
        sb_en = 1'b0;

        // COUNT wraps 0xFF -> 0x00
        send_cmd(OP_SET_MODE, 8'hFF, ap);
        send_cmd(OP_LOAD, 8'hFE, ap);
        send_cmd(OP_SET_SPEED, 8'd0, ap);
        push(8'hFF, ap + 4);
        push(8'h00, ap + 8);
        push(8'h01, ap + 12);
        @(negedge clk);
        check("count_load", leds, 8'hFE);
        check("count_mode_arg_masked", mode, 2'd3);
        sb_en = 1'b1;
        wait_drain("count_drain", 40);
        sb_en = 1'b0;

        // BLINK from a loaded pattern
        send_cmd(OP_SET_MODE, 8'd2, ap);
        send_cmd(OP_LOAD, 8'h0F, ap);
        push(8'hF0, ap + 4);
        push(8'h0F, ap + 8);
        push(8'hF0, ap + 12);
        @(negedge clk);
        check("blink_load", leds, 8'h0F);
        check("blink_mode", mode, 2'd2);
        sb_en = 1'b1;
        wait_drain("blink_drain", 40);
        sb_en = 1'b0;

        // Pause mid-interval, load while paused, resume
        send_cmd(OP_SET_MODE, 8'd0, ap);
        send_cmd(OP_SET_SPEED, 8'd1, ap);
        push(8'h02, ap + 8);
        sb_en = 1'b1;
        wait_drain("pre_pause_step", 40);
        send_cmd(OP_PAUSE, 8'h01, ap);
        @(negedge clk);
        check("paused_set", paused, 1);
        check("halt_ready", cmd_ready, 1);
        chg = 0;
        repeat (100) begin
            @(negedge clk);
            if (leds !== 8'h02) chg++;
        end
        check("pause_frozen", chg, 0);
        send_cmd(OP_LOAD, 8'hAA, ap);
        @(negedge clk);
        check("load_while_paused", leds, 8'hAA);
        check("load_no_pulse", step_pulse, 0);
        check("still_paused", paused, 1);
        send_cmd(OP_PAUSE, 8'h00, ap);
        push(8'h55, ap + 8);
        push(8'hAA, ap + 16);
        @(negedge clk);
        check("paused_clear", paused, 0);
        wait_drain("resume_drain", 40);
        sb_en = 1'b0;

        // cmd_valid held high across three commands
        @(negedge clk);
        k = 0;
        cmd_valid = 1'b1;
        cmd_op    = b2b_op[0][1:0];
        cmd_arg   = b2b_arg[0];
        for (int i = 0; i < 6; i++) begin
            check("b2b_ready", cmd_ready, (i % 2 == 0) ? 1 : 0);
            if (cmd_ready) k++;
            @(negedge clk);
            if (k < 3) begin
                cmd_op  = b2b_op[k][1:0];
                cmd_arg = b2b_arg[k];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        ap = cyc;
        check("b2b_leds", leds, 8'h10);
        check("b2b_mode", mode, 2'd3);
        push(8'h11, ap + 16);
        push(8'h12, ap + 32);
        push(8'h13, ap + 48);
        sb_en = 1'b1;

        // Command accepted on a step edge: step happens, then LOAD overrides
        while (cyc < ap + 47) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_arg   = 8'h77;
        check("step_edge_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("step_edge_leds", leds, 8'h13);
        @(negedge clk);
        check("override_leds", leds, 8'h77);
        check("override_no_pulse", step_pulse, 0);
        push(8'h78, ap + 49 + 16);
        wait_drain("override_drain", 40);
        sb_en = 1'b0;

        // Reset during APPLY of SET_MODE 2
        send_cmd(OP_PAUSE, 8'h01, ap);
        @(negedge clk);
        check("pre_rst_paused", paused, 1);
        cmd_valid = 1'b1;
        cmd_op    = OP_SET_MODE;
        cmd_arg   = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        check("rst_apply_ready", cmd_ready, 0);
        @(negedge clk);
        check("rst_apply_leds", leds, 8'h01);
        check("rst_apply_mode", mode, 2'd0);
        check("rst_apply_paused", paused, 0);
        check("rst_apply_ready1", cmd_ready, 1);
        check("rst_apply_pulse", step_pulse, 0);
        rst = 1'b0;
        rel = cyc;
        push(8'h02, rel + TD * 50);
        sb_en = 1'b1;
        wait_drain("post_rst_speed", 260);
        sb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
